// File: rtl/mem_stage_access_unit_if.sv
// Data-bus bundle between the MEM-stage access unit (master) and data memory (slave).
interface mem_stage_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_stage_access_unit.sv
// MEM-stage data-memory sequencer: big-endian req/ack bus access, pipeline stall,
// extended load data, and misalign/timeout pulses.
module mem_stage_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        R_n,
  input  logic        E_mem,
  input  logic        rw_dm_mem,
  input  logic [1:0]  size_mem,
  input  logic        se_mem,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  mem_stage_access_unit_if.master bus,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [7:0]  cnt;
  logic [29:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        se_q;
  logic        cause_to;

  logic        aligned;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] rdata_ext;

  always_comb begin
    aligned = 1'b1;
    be_d    = 4'b1111;
    wdata_d = wdata;
    case (size_mem)
      2'b00: begin
        be_d    = 4'b1000 >> addr[1:0];
        wdata_d = {4{wdata[7:0]}};
      end
      2'b01: begin
        aligned = ~addr[0];
        be_d    = addr[1] ? 4'b0011 : 4'b1100;
        wdata_d = {2{wdata[15:0]}};
      end
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  // Big-endian lane select: byte offset 0 lives in bits 31:24.
  function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] size,
                                          input logic [1:0] off, input logic se);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rdata >> {~off, 3'b000});
    h = off[1] ? rdata[15:0] : rdata[31:16];
    case (size)
      2'b00:   extract = {{24{se & b[7]}}, b};
      2'b01:   extract = {{16{se & h[15]}}, h};
      default: extract = rdata;
    endcase
  endfunction

  assign rdata_ext = extract(bus.bus_rdata, size_q, off_q, se_q);

  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    bus.bus_req = 1'b0;
    mem_stall   = 1'b0;
    load_valid  = 1'b0;
    misalign    = 1'b0;
    timeout_err = 1'b0;
    case (state)
      IDLE: begin
        mem_stall = E_mem;
        if (E_mem) state_next = aligned ? REQ : ERR;
      end
      REQ: begin
        bus.bus_req = 1'b1;
        mem_stall   = 1'b1;
        // Ack is checked first so an ack on the final allowed cycle still completes.
        if (bus.bus_ack)        state_next = DONE;
        else if (cnt == LAST)   state_next = ERR;
      end
      DONE: begin
        load_valid = ~we_q;
        state_next = IDLE;
      end
      default: begin
        misalign    = ~cause_to;
        timeout_err = cause_to;
        state_next  = IDLE;
      end
    endcase
    // Stall is combinational from E_mem; keep it low while reset is asserted.
    mem_stall = mem_stall & R_n;
  end

  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      cnt       <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      off_q     <= '0;
      se_q      <= 1'b0;
      cause_to  <= 1'b0;
      load_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (E_mem && aligned) begin
            addr_q  <= addr[31:2];
            we_q    <= rw_dm_mem;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            size_q  <= size_mem;
            off_q   <= addr[1:0];
            se_q    <= se_mem;
          end else if (E_mem) begin
            cause_to <= 1'b0;
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          if (bus.bus_ack) begin
            if (!we_q) load_data <= rdata_ext;
          end else if (cnt == LAST) begin
            cause_to <= 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = {addr_q, 2'b00};
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;
endmodule
